// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access size codes,
// controller state encoding, the latched-access record and lane helpers.
package dmem_pkg;

    // Access size codes as presented on the size pins; the reserved code
    // behaves as a word access everywhere.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Wait-state counter width; covers WAIT_CYCLES up to 15.
    localparam int WAIT_CNT_W = 4;

    // Everything about one access that must survive the wait states.
    typedef struct packed {
        logic        wr;
        size_e       size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } access_t;

    // Byte-lane write enables for a store. Halfwords only look at addr[1],
    // words ignore both low bits.
    function automatic logic [3:0] lane_enables(input size_e sz, input logic [1:0] lo);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data across every lane so whichever
    // lanes are enabled see the right bytes.
    function automatic logic [31:0] store_lanes(input size_e sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pick the addressed byte/halfword out of a memory word, right-justify
    // it and sign- or zero-extend to 32 bits.
    function automatic logic [31:0] load_extract(input size_e sz, input logic sext,
                                                 input logic [1:0] lo, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage array with per-byte write enables.
// Synchronous write, combinational (asynchronous) read.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Commit the enabled byte lanes of the addressed word.
    // NOTE: the array has no reset on purpose -- contents must survive a
    // controller reset, and a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: single-outstanding load/store front end with a
// configurable number of wait states, sub-word lanes and range faulting.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault misaligned half and
// word accesses; otherwise misaligned low address bits are ignored.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter value loaded on entering WAIT; WAIT lasts WAIT_LOAD+1 cycles.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    access_t               acc_q, acc_d, acc_in, cur;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  out_of_range;
    logic                  misaligned;
    logic                  fault;
    logic                  enter_done;

    logic                  bank_we;
    logic [3:0]            bank_be;
    logic [AW-1:0]         bank_addr;
    logic [31:0]           bank_wdata;
    logic [31:0]           bank_rdata;

    // Gather the request pins into one access record.
    always_comb begin
        acc_in.wr    = wr;
        acc_in.size  = size_e'(size);
        acc_in.sext  = sext;
        acc_in.addr  = addr;
        acc_in.wdata = wdata;
    end

    // The access being worked on: the live pins while IDLE (a zero-wait
    // access completes on its accepting edge), the latched copy afterwards.
    assign cur = (state_q == ST_IDLE) ? acc_in : acc_q;

    // Anything at or above 4*DEPTH_WORDS bytes has a non-zero upper slice.
    assign out_of_range = |cur.addr[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
    // Halfwords must be 2-byte aligned, words (and reserved size) 4-byte aligned.
    always_comb begin
        misaligned = 1'b0;
        case (cur.size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = cur.addr[0];
            default: misaligned = |cur.addr[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign fault = out_of_range | misaligned;

    // Next-state and wait-counter logic.
    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The edge that moves the FSM into DONE is the one that commits the
    // store and captures the load result.
    assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

    // Latch the request on acceptance; later req pulses are simply ignored.
    always_comb begin
        acc_d = acc_q;
        if (state_q == ST_IDLE && req) begin
            acc_d = acc_in;
        end
    end

    // Completion result: zero data for stores and faults, error flag with it.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_done) begin
            err_d   = fault;
            rdata_d = (fault || cur.wr) ? 32'h0
                                        : load_extract(cur.size, cur.sext, cur.addr[1:0], bank_rdata);
        end
    end

    // Bank hookup. A held reset suppresses the write so an access that was
    // about to complete is dropped cleanly.
    assign bank_we    = enter_done && cur.wr && !fault && !reset;
    assign bank_be    = lane_enables(cur.size, cur.addr[1:0]);
    assign bank_addr  = cur.addr[AW+1:2];
    assign bank_wdata = store_lanes(cur.size, cur.wdata);

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .be    (bank_be),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    // Controller state registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ready is the DONE state; err is only meaningful alongside it. busy
    // covers the accepting cycle (req seen in IDLE) through the DONE cycle.
    assign ready = (state_q == ST_DONE);
    assign err   = ready & err_q;
    assign busy  = !reset && ((state_q != ST_IDLE) || req);
    assign rdata = rdata_q;

endmodule
